// File: rtl/mem_boot_ctrl_pkg.sv
// Shared types and constants for the memory boot controller:
// FSM state encoding, external-port address strides and the CPU STOP opcode.
package mem_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_RUN    = 3'd3,
        ST_DUMP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Byte address = word index << stride (imem 4-byte words, dmem 8-byte words)
    localparam int IMEM_STRIDE_SH = 2;
    localparam int DMEM_STRIDE_SH = 3;

    localparam logic [6:0] STOP_OPCODE = 7'b1111110;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_LOAD_D) || (s == ST_LOAD_I) || (s == ST_RUN) || (s == ST_DUMP);
    endfunction

endpackage

// File: rtl/mem_boot_rd_pipe.sv
// Read-return pipe for the dmem dump: tracks each issued read for one cycle,
// then registers the returned word together with its index.
module mem_boot_rd_pipe
    import mem_boot_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    input  logic [DATA_W-1:0] rdata,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [AW-1:0]     dump_idx
);

    logic          pend_valid_r;
    logic [AW-1:0] pend_idx_r;

    // Memory answers one cycle after ren, so the word is captured one cycle later still
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_valid_r <= 1'b0;
            pend_idx_r   <= {AW{1'b0}};
            dump_valid   <= 1'b0;
            dump_data    <= {DATA_W{1'b0}};
            dump_idx     <= {AW{1'b0}};
        end else begin
            pend_valid_r <= rd_en;
            pend_idx_r   <= rd_idx;
            dump_valid   <= pend_valid_r;
            if (pend_valid_r) begin
                dump_data <= rdata;
                dump_idx  <= pend_idx_r;
            end else begin
                dump_data <= dump_data;
                dump_idx  <= dump_idx;
            end
        end
    end

endmodule

// File: rtl/mem_boot_ctrl.sv
// Boot sequencer: streams a preload image into dmem then imem, runs the CPU
// until halt, then streams a dmem window back out.
module mem_boot_ctrl
    import mem_boot_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          start,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [DATA_W-1:0]             src_data,
    input  logic                          halt,
    input  logic [$clog2(DMEM_WORDS)-1:0] dump_first,
    input  logic [$clog2(DMEM_WORDS):0]   dump_len,
    output logic [63:0]                   addr_ext,
    output logic                          wen_ext,
    output logic                          ren_ext,
    output logic [DATA_W-1:0]             wdata_ext,
    output logic [63:0]                   addr_ext_2,
    output logic                          wen_ext_2,
    output logic                          ren_ext_2,
    output logic [DATA_W-1:0]             wdata_ext_2,
    input  logic [DATA_W-1:0]             rdata_ext_2,
    output logic                          cpu_enable,
    output logic                          dump_valid,
    output logic [DATA_W-1:0]             dump_data,
    output logic [$clog2(DMEM_WORDS)-1:0] dump_idx,
    output logic [CNT_W-1:0]              run_cycles,
    output logic                          busy,
    output logic                          done
);

    localparam int AW   = $clog2(DMEM_WORDS);
    localparam int MAXW = (DMEM_WORDS > IMEM_WORDS) ? DMEM_WORDS : IMEM_WORDS;
    localparam int WCW  = $clog2(MAXW);
    localparam logic [WCW-1:0] D_LAST  = WCW'(DMEM_WORDS - 1);
    localparam logic [WCW-1:0] I_LAST  = WCW'(IMEM_WORDS - 1);
    localparam logic [AW:0]    D_WORDS = (AW+1)'(DMEM_WORDS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1'b1);
    endfunction

    state_t              state_r, state_s;
    logic [WCW-1:0]      wcnt_r, wcnt_s;
    logic [CNT_W-1:0]    run_cycles_r, run_cycles_s;
    logic                cpu_enable_r, cpu_enable_s;
    logic [63:0]         addr_ext_r, addr_ext_s, addr_ext_2_r, addr_ext_2_s;
    logic                wen_ext_r, wen_ext_s, wen_ext_2_r, wen_ext_2_s, ren_ext_2_r, ren_ext_2_s;
    logic [DATA_W-1:0]   wdata_ext_r, wdata_ext_s, wdata_ext_2_r, wdata_ext_2_s;
    logic [AW-1:0]       ridx_r, ridx_s, ridx_inc_s;
    logic [AW:0]         rem_r, rem_s, avail_s, win_len_s;
    logic                drain_r, drain_s, busy_r, done_r;

    // Window is clipped at the top of dmem; reads never wrap
    assign avail_s    = D_WORDS - {1'b0, dump_first};
    assign win_len_s  = (dump_len < avail_s) ? dump_len : avail_s;
    assign ridx_inc_s = ridx_r + AW'(1'b1);
    assign src_ready  = (state_r == ST_LOAD_D) || (state_r == ST_LOAD_I);

    // Next-state and next-output logic
    always_comb begin
        state_s       = state_r;
        wcnt_s        = wcnt_r;
        run_cycles_s  = run_cycles_r;
        cpu_enable_s  = 1'b0;
        addr_ext_s    = addr_ext_r;
        wen_ext_s     = 1'b0;
        wdata_ext_s   = wdata_ext_r;
        addr_ext_2_s  = addr_ext_2_r;
        wen_ext_2_s   = 1'b0;
        ren_ext_2_s   = 1'b0;
        wdata_ext_2_s = wdata_ext_2_r;
        ridx_s        = ridx_r;
        rem_s         = rem_r;
        drain_s       = drain_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s      = ST_LOAD_D;
                    wcnt_s       = {WCW{1'b0}};
                    run_cycles_s = {CNT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD_D: begin
                if (src_valid) begin
                    wen_ext_2_s   = 1'b1;
                    addr_ext_2_s  = 64'(wcnt_r) << DMEM_STRIDE_SH;
                    wdata_ext_2_s = src_data;
                    if (wcnt_r == D_LAST) begin
                        state_s = ST_LOAD_I;
                        wcnt_s  = {WCW{1'b0}};
                    end else begin
                        wcnt_s = wcnt_r + WCW'(1'b1);
                    end
                end else begin
                    wen_ext_2_s = 1'b0;
                end
            end
            ST_LOAD_I: begin
                if (src_valid) begin
                    wen_ext_s   = 1'b1;
                    addr_ext_s  = 64'(wcnt_r) << IMEM_STRIDE_SH;
                    wdata_ext_s = src_data;
                    if (wcnt_r == I_LAST) begin
                        state_s = ST_RUN;
                        wcnt_s  = {WCW{1'b0}};
                    end else begin
                        wcnt_s = wcnt_r + WCW'(1'b1);
                    end
                end else begin
                    wen_ext_s = 1'b0;
                end
            end
            ST_RUN: begin
                // Count only the cycles in which the CPU was actually enabled
                if (cpu_enable_r) begin
                    run_cycles_s = sat_inc(run_cycles_r);
                end else begin
                    run_cycles_s = run_cycles_r;
                end
                if (halt) begin
                    ridx_s  = dump_first;
                    rem_s   = win_len_s - (AW+1)'(1'b1);
                    drain_s = 1'b0;
                    if (dump_len != {(AW+1){1'b0}}) begin
                        state_s      = ST_DUMP;
                        ren_ext_2_s  = 1'b1;
                        addr_ext_2_s = 64'(dump_first) << DMEM_STRIDE_SH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    cpu_enable_s = 1'b1;
                end
            end
            ST_DUMP: begin
                if (ren_ext_2_r) begin
                    if (rem_r != {(AW+1){1'b0}}) begin
                        ren_ext_2_s  = 1'b1;
                        ridx_s       = ridx_inc_s;
                        addr_ext_2_s = 64'(ridx_inc_s) << DMEM_STRIDE_SH;
                        rem_s        = rem_r - (AW+1)'(1'b1);
                    end else begin
                        ren_ext_2_s = 1'b0;
                    end
                end else if (drain_r) begin
                    state_s = ST_DONE;
                end else begin
                    drain_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r       <= ST_IDLE;
            wcnt_r        <= {WCW{1'b0}};
            run_cycles_r  <= {CNT_W{1'b0}};
            cpu_enable_r  <= 1'b0;
            addr_ext_r    <= 64'd0;
            wen_ext_r     <= 1'b0;
            wdata_ext_r   <= {DATA_W{1'b0}};
            addr_ext_2_r  <= 64'd0;
            wen_ext_2_r   <= 1'b0;
            ren_ext_2_r   <= 1'b0;
            wdata_ext_2_r <= {DATA_W{1'b0}};
            ridx_r        <= {AW{1'b0}};
            rem_r         <= {(AW+1){1'b0}};
            drain_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            wcnt_r        <= wcnt_s;
            run_cycles_r  <= run_cycles_s;
            cpu_enable_r  <= cpu_enable_s;
            addr_ext_r    <= addr_ext_s;
            wen_ext_r     <= wen_ext_s;
            wdata_ext_r   <= wdata_ext_s;
            addr_ext_2_r  <= addr_ext_2_s;
            wen_ext_2_r   <= wen_ext_2_s;
            ren_ext_2_r   <= ren_ext_2_s;
            wdata_ext_2_r <= wdata_ext_2_s;
            ridx_r        <= ridx_s;
            rem_r         <= rem_s;
            drain_r       <= drain_s;
            busy_r        <= is_busy_state(state_s);
            done_r        <= (state_s == ST_DONE);
        end
    end

    mem_boot_rd_pipe #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_rd_pipe (
        .clk        (clk),
        .arst_n     (arst_n),
        .rd_en      (ren_ext_2_r),
        .rd_idx     (ridx_r),
        .rdata      (rdata_ext_2),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx)
    );

    assign addr_ext    = addr_ext_r;
    assign wen_ext     = wen_ext_r;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_ext_r;
    assign addr_ext_2  = addr_ext_2_r;
    assign wen_ext_2   = wen_ext_2_r;
    assign ren_ext_2   = ren_ext_2_r;
    assign wdata_ext_2 = wdata_ext_2_r;
    assign cpu_enable  = cpu_enable_r;
    assign run_cycles  = run_cycles_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
